// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
// Next-address source encoding and the target alignment test.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ,
    PC_HOLD,
    PC_BRANCH,
    PC_JUMP,
    PC_RET,
    PC_TRAP
  } pc_src_e;

  function automatic logic is_aligned(
    input logic [63:0] addr,
    input int          ib
  );
    logic [63:0] m;
    m = 64'(ib - 1);
    return (addr & m) == 64'd0;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push when full drops the oldest entry.
// Pop data is the entry under the top-of-stack pointer.
module pc_ras #(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_data,
  output logic [AW-1:0]            pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_up;
  logic [AW-1:0] mem [DEPTH];

  assign ptr_up   = ptr + PW'(1);
  assign pop_data = mem[ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_up;
      if (count != CW'(DEPTH))
        count <= count + CW'(1);
    end else if (pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry contents need no reset; only ptr/count define validity
  always_ff @(posedge clk) begin
    if (push)
      mem[ptr_up] <= push_data;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-address select, RAS,
// alignment check and one-cycle fault pulses.
module pc_unit
  import pc_pkg::*;
#(
  parameter int          AW           = 32,
  parameter int          INSTR_BYTES  = 4,
  parameter logic [AW-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [AW-1:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [AW-1:0]                branch_target,
  input  logic                         jump,
  input  logic                         call,
  input  logic [AW-1:0]                jump_target,
  input  logic                         ret,
  input  logic                         trap,
  output logic [AW-1:0]                address,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign,
  output logic                         ras_underflow
);

  pc_src_e       src;
  logic [AW-1:0] seq;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] ras_top;
  logic          push;
  logic          pop;
  logic          mis_d;
  logic          unf_d;

  assign seq = address + AW'(INSTR_BYTES);

  always_comb begin
    src   = PC_SEQ;
    push  = 1'b0;
    pop   = 1'b0;
    mis_d = 1'b0;
    unf_d = 1'b0;
    if (trap) begin
      src = PC_TRAP;
    end else if (stall) begin
      src = PC_HOLD;
    end else if (ret) begin
      if (ras_count != '0) begin
        src = PC_RET;
        pop = 1'b1;
      end else begin
        src   = PC_TRAP;
        unf_d = 1'b1;
      end
    end else if (jump) begin
      if (is_aligned(64'(jump_target), INSTR_BYTES)) begin
        src  = PC_JUMP;
        push = call;
      end else begin
        src   = PC_TRAP;
        mis_d = 1'b1;
      end
    end else if (branch_taken) begin
      if (is_aligned(64'(branch_target), INSTR_BYTES)) begin
        src = PC_BRANCH;
      end else begin
        src   = PC_TRAP;
        mis_d = 1'b1;
      end
    end
  end

  always_comb begin
    next_addr = seq;
    unique case (src)
      PC_HOLD:   next_addr = address;
      PC_RET:    next_addr = ras_top;
      PC_JUMP:   next_addr = jump_target;
      PC_BRANCH: next_addr = branch_target;
      PC_TRAP:   next_addr = TRAP_VECTOR;
      default:   next_addr = seq;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address       <= RESET_VECTOR;
      misalign      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      address       <= next_addr;
      misalign      <= mis_d;
      ras_underflow <= unf_d;
    end
  end

  pc_ras #(
    .AW    (AW),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (seq),
    .pop_data  (ras_top),
    .count     (ras_count)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a queue-based reference model
// compared every cycle, plus literal spot checks.
module tb_pc_unit;

  localparam logic [31:0] TV = 32'h80;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump, call, ret, trap;
  logic [31:0] branch_target, jump_target;
  logic [31:0] address;
  logic [2:0]  ras_count;
  logic        misalign, ras_underflow;

  int errors = 0;
  int checks = 0;

  pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .call          (call),
    .jump_target   (jump_target),
    .ret           (ret),
    .trap          (trap),
    .address       (address),
    .ras_count     (ras_count),
    .misalign      (misalign),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  // Reference model: address plus an unbounded queue trimmed to 4
  logic [31:0] m_addr;
  logic        m_mis, m_unf;
  logic [31:0] m_ras [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr = 32'h0;
      m_mis  = 1'b0;
      m_unf  = 1'b0;
      m_ras.delete();
    end else begin
      logic [31:0] s;
      s     = m_addr + 32'd4;
      m_mis = 1'b0;
      m_unf = 1'b0;
      if (trap) begin
        m_addr = TV;
      end else if (stall) begin
        m_addr = m_addr;
      end else if (ret) begin
        if (m_ras.size() > 0) begin
          m_addr = m_ras.pop_back();
        end else begin
          m_addr = TV;
          m_unf  = 1'b1;
        end
      end else if (jump) begin
        if (jump_target % 4 != 0) begin
          m_addr = TV;
          m_mis  = 1'b1;
        end else begin
          if (call) begin
            m_ras.push_back(s);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
          end
          m_addr = jump_target;
        end
      end else if (branch_taken) begin
        if (branch_target % 4 != 0) begin
          m_addr = TV;
          m_mis  = 1'b1;
        end else begin
          m_addr = branch_target;
        end
      end else begin
        m_addr = s;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (address !== m_addr || int'(ras_count) != m_ras.size()
        || misalign !== m_mis || ras_underflow !== m_unf) begin
      errors++;
      $display("FAIL model t=%0t addr=%h/%h cnt=%0d/%0d mis=%b/%b unf=%b/%b",
               $time, address, m_addr, ras_count, m_ras.size(),
               misalign, m_mis, ras_underflow, m_unf);
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic clr();
    stall = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; trap = 0;
    branch_target = 0; jump_target = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_call(input logic [31:0] t);
    clr(); jump = 1; call = 1; jump_target = t;
    tick();
  endtask

  task automatic do_ret();
    clr(); ret = 1;
    tick();
  endtask

  initial begin
    clr();
    rst_n = 0;
    tick(); tick();
    chk("reset_addr", address, 32'h0);
    chk("reset_cnt", 32'(ras_count), 32'h0);
    rst_n = 1;
    tick(); chk("seq4", address, 32'h4);
    tick(); chk("seq8", address, 32'h8);
    tick(); chk("seqC", address, 32'hC);
    rst_n = 0;
    #1 chk("async_rst", address, 32'h0);
    #2 rst_n = 1;
    repeat (4) tick();
    chk("at10", address, 32'h10);
    stall = 1;
    repeat (3) tick();
    chk("stall", address, 32'h10);
    trap = 1;
    tick(); chk("trap_stall", address, TV);

    clr(); jump = 1; jump_target = 32'h20;
    tick(); chk("jump20", address, 32'h20);
    do_call(32'h100);
    chk("call", address, 32'h100);
    chk("call_cnt", 32'(ras_count), 32'h1);
    clr(); tick();
    do_ret();
    chk("ret", address, 32'h24);
    chk("ret_cnt", 32'(ras_count), 32'h0);

    rst_n = 0;
    #2 rst_n = 1;
    clr();
    do_call(32'h100); do_call(32'h200); do_call(32'h300);
    do_call(32'h400); do_call(32'h500);
    chk("ovf_cnt", 32'(ras_count), 32'h4);
    do_ret(); chk("pop404", address, 32'h404);
    do_ret(); chk("pop304", address, 32'h304);
    do_ret(); chk("pop204", address, 32'h204);
    do_ret(); chk("pop104", address, 32'h104);
    do_ret(); chk("unf_addr", address, TV);
    chk("unf_pulse", 32'(ras_underflow), 32'h1);
    clr(); tick();
    chk("unf_clear", 32'(ras_underflow), 32'h0);

    branch_taken = 1; branch_target = 32'h102;
    tick(); chk("mis_addr", address, TV);
    chk("mis_pulse", 32'(misalign), 32'h1);
    clr(); tick();
    chk("mis_clear", 32'(misalign), 32'h0);
    do_call(32'h200);
    do_call(32'h3);
    chk("mis_call", address, TV);
    chk("mis_cnt", 32'(ras_count), 32'h1);

    clr(); jump = 1; jump_target = 32'hFFFF_FFFC;
    tick(); clr(); tick();
    chk("wrap", address, 32'h0);
    ret = 1; jump = 1; jump_target = 32'h400;
    branch_taken = 1; branch_target = 32'h500;
    tick();
    chk("prio_ret", address, 32'h88);
    chk("prio_cnt", 32'(ras_count), 32'h0);
    clr(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
